// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    localparam int DefAddrWidth     = 8;
    localparam int DefDataWidth     = 8;
    localparam int DefTimeoutCycles = 16;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive memory-wait cycles and flags the TimeoutCycles-th one
// so the sequencer can give up on a missing acknowledge.
module fetch_timeout_ctr #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q;

    // Dropping count_i outside the wait state clears the counter for the next entry.
    always_ff @(posedge clk_i) begin
        if (reset_i || !count_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LastCount) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign expired_o = count_i && (cnt_q == LastCount);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: drives the PC counter, runs the memory read and
// holds the fetched word for the decoder. Optional wait timeout: FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int AddrWidth     = DefAddrWidth,
    parameter int DataWidth     = DefDataWidth,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [AddrWidth-1:0] PC_Q,
    output logic                 PC_OE_n,
    output logic                 PC_Load_n,
    output logic                 PC_Enable,
    output logic [AddrWidth-1:0] PC_D,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic                 Mem_Req,
    input  logic                 Mem_Ack,
    input  logic [DataWidth-1:0] Mem_Data,
    input  logic                 Branch,
    input  logic [AddrWidth-1:0] Branch_Target,
    output logic [DataWidth-1:0] IR,
    output logic                 IR_Valid,
    input  logic                 IR_Ready,
    output logic                 Fault
);

    state_e               state_q, state_d;
    logic [DataWidth-1:0] ir_q, ir_d;
    logic                 irValid_q, irValid_d;
    logic                 memReq_q, memReq_d;
    logic [AddrWidth-1:0] memAddr_q, memAddr_d;
    logic [AddrWidth-1:0] pcD_q, pcD_d;
    logic                 pcOeN_q, pcOeN_d;
    logic                 pcLoadN_q, pcLoadN_d;
    logic                 pcEnable_q, pcEnable_d;
    logic                 pending_q, pending_d;
    logic [AddrWidth-1:0] pendTarget_q, pendTarget_d;

`ifdef FETCH_TIMEOUT_EN
    logic fault_q, fault_d;
    logic timeoutExpired;

    fetch_timeout_ctr #(
        .TimeoutCycles(TimeoutCycles)
    ) uTimeout (
        .clk_i    (Clk),
        .reset_i  (Reset),
        .count_i  (state_q == S_WAIT),
        .expired_o(timeoutExpired)
    );

    assign Fault = fault_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TimeoutCycles;
    assign Fault = 1'b0;
`endif

    // Strobes default to inactive so every pulse lasts exactly one cycle.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        irValid_d    = irValid_q;
        memReq_d     = memReq_q;
        memAddr_d    = memAddr_q;
        pcD_d        = pcD_q;
        pcOeN_d      = 1'b1;
        pcLoadN_d    = 1'b1;
        pcEnable_d   = 1'b0;
        pending_d    = pending_q;
        pendTarget_d = pendTarget_q;
`ifdef FETCH_TIMEOUT_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            S_IDLE, S_ADDR, S_HOLD: begin
                if (Branch) begin
                    irValid_d = 1'b0;
                    memReq_d  = 1'b0;
                    pcLoadN_d = 1'b0;
                    pcD_d     = Branch_Target;
                    state_d   = S_IDLE;
                end else if (state_q == S_IDLE) begin
                    pcOeN_d = 1'b0;
                    state_d = S_ADDR;
                end else if (state_q == S_ADDR) begin
                    memAddr_d = PC_Q;
                    memReq_d  = 1'b1;
                    state_d   = S_WAIT;
                end else if (IR_Ready) begin
                    irValid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                if (Mem_Ack) begin
                    memReq_d = 1'b0;
                    // A branch seen during the read makes the returned word stale.
                    if (pending_q || Branch) begin
                        pcLoadN_d = 1'b0;
                        pcD_d     = Branch ? Branch_Target : pendTarget_q;
                        pending_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        ir_d       = Mem_Data;
                        irValid_d  = 1'b1;
                        pcEnable_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else begin
                    if (Branch) begin
                        pending_d    = 1'b1;
                        pendTarget_d = Branch_Target;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (timeoutExpired) begin
                        memReq_d  = 1'b0;
                        pending_d = 1'b0;
                        fault_d   = 1'b1;
                        state_d   = S_FAULT;
                    end
`endif
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_FAULT: begin
                irValid_d = 1'b0;
                memReq_d  = 1'b0;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            irValid_q    <= 1'b0;
            memReq_q     <= 1'b0;
            memAddr_q    <= '0;
            pcD_q        <= '0;
            pcOeN_q      <= 1'b1;
            pcLoadN_q    <= 1'b1;
            pcEnable_q   <= 1'b0;
            pending_q    <= 1'b0;
            pendTarget_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            irValid_q    <= irValid_d;
            memReq_q     <= memReq_d;
            memAddr_q    <= memAddr_d;
            pcD_q        <= pcD_d;
            pcOeN_q      <= pcOeN_d;
            pcLoadN_q    <= pcLoadN_d;
            pcEnable_q   <= pcEnable_d;
            pending_q    <= pending_d;
            pendTarget_q <= pendTarget_d;
`ifdef FETCH_TIMEOUT_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign IR        = ir_q;
    assign IR_Valid  = irValid_q;
    assign Mem_Req   = memReq_q;
    assign Mem_Addr  = memAddr_q;
    assign PC_D      = pcD_q;
    assign PC_OE_n   = pcOeN_q;
    assign PC_Load_n = pcLoadN_q;
    assign PC_Enable = pcEnable_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change and outputs are sampled on
// the falling edge; expected values are written out by hand per step.
module tb_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] PC_Q;
    logic       PC_OE_n;
    logic       PC_Load_n;
    logic       PC_Enable;
    logic [7:0] PC_D;
    logic [7:0] Mem_Addr;
    logic       Mem_Req;
    logic       Mem_Ack;
    logic [7:0] Mem_Data;
    logic       Branch;
    logic [7:0] Branch_Target;
    logic [7:0] IR;
    logic       IR_Valid;
    logic       IR_Ready;
    logic       Fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    fetch_sequencer #(
        .AddrWidth    (8),
        .DataWidth    (8),
        .TimeoutCycles(4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PC_Q         (PC_Q),
        .PC_OE_n      (PC_OE_n),
        .PC_Load_n    (PC_Load_n),
        .PC_Enable    (PC_Enable),
        .PC_D         (PC_D),
        .Mem_Addr     (Mem_Addr),
        .Mem_Req      (Mem_Req),
        .Mem_Ack      (Mem_Ack),
        .Mem_Data     (Mem_Data),
        .Branch       (Branch),
        .Branch_Target(Branch_Target),
        .IR           (IR),
        .IR_Valid     (IR_Valid),
        .IR_Ready     (IR_Ready),
        .Fault        (Fault)
    );

    // Drives one cycle of inputs, then lets exactly one rising edge pass.
    task automatic applyStimulus(input logic rst, input logic ack, input logic [7:0] data,
                                 input logic br, input logic [7:0] tgt, input logic rdy);
        Reset         = rst;
        Mem_Ack       = ack;
        Mem_Data      = data;
        Branch        = br;
        Branch_Target = tgt;
        IR_Ready      = rdy;
        @(negedge Clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    initial begin
        Reset = 1'b1; PC_Q = 8'h10; Mem_Ack = 1'b0; Mem_Data = '0;
        Branch = 1'b0; Branch_Target = '0; IR_Ready = 1'b0;

        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("rst_IR", IR, 0);
        checkOutput("rst_IR_Valid", IR_Valid, 0);
        checkOutput("rst_Mem_Req", Mem_Req, 0);
        checkOutput("rst_Mem_Addr", Mem_Addr, 0);
        checkOutput("rst_PC_D", PC_D, 0);
        checkOutput("rst_PC_OE_n", PC_OE_n, 1);
        checkOutput("rst_PC_Load_n", PC_Load_n, 1);
        checkOutput("rst_PC_Enable", PC_Enable, 0);
        checkOutput("rst_Fault", Fault, 0);

        // Basic fetch: request lands two cycles after reset release.
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("idle_OE", PC_OE_n, 0);
        checkOutput("idle_Req", Mem_Req, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("addr_Req", Mem_Req, 1);
        checkOutput("addr_Addr", Mem_Addr, 8'h10);
        checkOutput("addr_OE", PC_OE_n, 1);
        applyStimulus(0, 1, 8'hA5, 0, 8'h00, 1);
        checkOutput("ack_IR", IR, 8'hA5);
        checkOutput("ack_Valid", IR_Valid, 1);
        checkOutput("ack_Enable", PC_Enable, 1);
        checkOutput("ack_Req", Mem_Req, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("hold_Valid", IR_Valid, 0);
        checkOutput("hold_Enable", PC_Enable, 0);
        checkOutput("hold_IR", IR, 8'hA5);
        PC_Q = 8'h11;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("b2b_Req", Mem_Req, 1);
        checkOutput("b2b_Addr", Mem_Addr, 8'h11);

        // Slow memory: acknowledge arrives in the fifth request cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'hEE, 0, 8'h00, 0);
            checkOutput("slow_Req", Mem_Req, 1);
            checkOutput("slow_Enable", PC_Enable, 0);
            checkOutput("slow_IR", IR, 8'hA5);
        end
        applyStimulus(0, 1, 8'h3C, 0, 8'h00, 0);
        checkOutput("slow_ackIR", IR, 8'h3C);
        checkOutput("slow_ackEnable", PC_Enable, 1);

        // Decoder stalls for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'hEE, 0, 8'h00, 0);
            checkOutput("stall_Valid", IR_Valid, 1);
            checkOutput("stall_IR", IR, 8'h3C);
            checkOutput("stall_Req", Mem_Req, 0);
            checkOutput("stall_Enable", PC_Enable, 0);
            checkOutput("stall_OE", PC_OE_n, 1);
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("stall_release", IR_Valid, 0);
        PC_Q = 8'h12;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("refetch_Addr", Mem_Addr, 8'h12);

        // Branches during the read: the later target wins, the data is dropped.
        applyStimulus(0, 0, 8'h00, 1, 8'h30, 1);
        checkOutput("wbr_Req", Mem_Req, 1);
        checkOutput("wbr_Load", PC_Load_n, 1);
        applyStimulus(0, 0, 8'h00, 1, 8'h40, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 1, 8'h77, 0, 8'h00, 1);
        checkOutput("wbr_LoadPulse", PC_Load_n, 0);
        checkOutput("wbr_PC_D", PC_D, 8'h40);
        checkOutput("wbr_Enable", PC_Enable, 0);
        checkOutput("wbr_IR", IR, 8'h3C);
        checkOutput("wbr_Valid", IR_Valid, 0);
        checkOutput("wbr_ReqDrop", Mem_Req, 0);
        PC_Q = 8'h40;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("wbr_LoadEnd", PC_Load_n, 1);
        checkOutput("wbr_OE", PC_OE_n, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("wbr_newAddr", Mem_Addr, 8'h40);
        applyStimulus(0, 1, 8'h66, 0, 8'h00, 1);
        checkOutput("wbr_cleared_IR", IR, 8'h66);
        checkOutput("wbr_cleared_Valid", IR_Valid, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("pre_rst_Req", Mem_Req, 1);

        // Reset mid-read, with the acknowledge turning up one cycle late.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("mrst_Req", Mem_Req, 0);
        checkOutput("mrst_OE", PC_OE_n, 1);
        applyStimulus(0, 1, 8'h99, 0, 8'h00, 1);
        checkOutput("mrst_Valid", IR_Valid, 0);
        checkOutput("mrst_IR", IR, 0);
        checkOutput("mrst_Req2", Mem_Req, 0);
        checkOutput("mrst_OE2", PC_OE_n, 0);
        PC_Q = 8'h55;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("mrst_restartReq", Mem_Req, 1);
        checkOutput("mrst_restartAddr", Mem_Addr, 8'h55);

        // Branch together with IR_Ready in hold, then a branch in the address cycle.
        applyStimulus(0, 1, 8'h5A, 0, 8'h00, 1);
        checkOutput("hbr_IR", IR, 8'h5A);
        applyStimulus(0, 0, 8'h00, 1, 8'h80, 1);
        checkOutput("hbr_Valid", IR_Valid, 0);
        checkOutput("hbr_Load", PC_Load_n, 0);
        checkOutput("hbr_PC_D", PC_D, 8'h80);
        checkOutput("hbr_Enable", PC_Enable, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("hbr_LoadEnd", PC_Load_n, 1);
        applyStimulus(0, 0, 8'h00, 1, 8'hC0, 1);
        checkOutput("abr_Req", Mem_Req, 0);
        checkOutput("abr_Load", PC_Load_n, 0);
        checkOutput("abr_PC_D", PC_D, 8'hC0);
        checkOutput("abr_OE", PC_OE_n, 1);
        PC_Q = 8'hC0;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("abr_Req2", Mem_Req, 1);
        checkOutput("abr_Addr", Mem_Addr, 8'hC0);

`ifdef FETCH_TIMEOUT_EN
        // Four wait cycles without acknowledge trip the sticky fault.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
            checkOutput("to_Req", Mem_Req, 1);
            checkOutput("to_Fault", Fault, 0);
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("to_FaultSet", Fault, 1);
        checkOutput("to_ReqDrop", Mem_Req, 0);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
        checkOutput("to_stuckFault", Fault, 1);
        checkOutput("to_stuckValid", IR_Valid, 0);
        checkOutput("to_stuckLoad", PC_Load_n, 1);
        checkOutput("to_stuckEnable", PC_Enable, 0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("to_rstFault", Fault, 0);
`else
        // Without the timeout the request simply waits.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
            checkOutput("nto_Fault", Fault, 0);
        end
        checkOutput("nto_Req", Mem_Req, 1);
        applyStimulus(0, 1, 8'h12, 0, 8'h00, 1);
        checkOutput("nto_IR", IR, 8'h12);
        checkOutput("nto_Valid", IR_Valid, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
